// File: rtl/top_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the Sobel filter.
package top_pkg;

  // Default frame geometry and pixel width.
  localparam int unsigned PxSizeDef      = 8;
  localparam int unsigned ImageWidthDef  = 1531;
  localparam int unsigned ImageHeightDef = 1080;

  // Frame state: RUN accepts pixels, FLUSH drains the last lines with zeros.
  typedef logic [0:0] state_t;
  localparam state_t StRun   = 1'b0;
  localparam state_t StFlush = 1'b1;

  // Signed gradient width: two's-complement range of +/-4*(2^px-1).
  function automatic int unsigned grad_w(int unsigned px);
    return px + 3;
  endfunction

  // Magnitude width: |Gx|+|Gy| before saturation.
  function automatic int unsigned mag_w(int unsigned px);
    return px + 4;
  endfunction

  // Counter width able to hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Depth-deep delay line with enable: data_o is the word written Depth enables ago.
module line_buffer #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PW-1:0] PtrLast = PW'(Depth - 1);

  // Storage is never reset; stale words only ever feed border or absent outputs.
  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    ptr_q, ptr_d;

  // The slot about to be overwritten holds the oldest word.
  assign data_o = mem_q[ptr_q];

  // Advance the circular pointer on every enabled step.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PtrLast) ? '0 : ptr_q + PW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // RAM write.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/top.sv
// Streaming 3x3 Sobel gradient magnitude over a raster frame, no backpressure.
module top
  import top_pkg::*;
#(
  parameter int unsigned PX_SIZE      = PxSizeDef,
  parameter int unsigned IMAGE_WIDTH  = ImageWidthDef,
  parameter int unsigned IMAGE_HEIGHT = ImageHeightDef
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PX_SIZE-1:0] input_data,
  input  logic               input_data_valid,
  output logic [PX_SIZE-1:0] output_data,
  output logic               output_data_valid
);

  localparam int unsigned GW = grad_w(PX_SIZE);
  localparam int unsigned MW = mag_w(PX_SIZE);
  localparam int unsigned CW = cnt_w(IMAGE_WIDTH + 2);
  localparam int unsigned RW = cnt_w(IMAGE_HEIGHT);

  localparam logic [CW-1:0] ColLast   = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] FillDone  = CW'(IMAGE_WIDTH + 1);
  localparam logic [CW-1:0] FlushLast = CW'(IMAGE_WIDTH);
  localparam logic [RW-1:0] RowLast   = RW'(IMAGE_HEIGHT - 1);
  localparam logic [MW-1:0] PxMax     = MW'({PX_SIZE{1'b1}});

  state_t        state_q, state_d;
  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  // Steps taken this frame, saturating once the window centre is valid.
  logic [CW-1:0] fill_q, fill_d;
  // Raster position of the centre pixel whose result is emitted next.
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] out_row_q, out_row_d;

  logic [PX_SIZE-1:0] win_q [3][3];
  logic [PX_SIZE-1:0] win_d [3][3];

  logic [PX_SIZE-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic               step, emit, border;
  logic [PX_SIZE-1:0] pix, lb0_out, lb1_out;

  // One pipeline step per accepted pixel in RUN, one per clock in FLUSH (fed zeros).
  assign step = (state_q == StRun) ? input_data_valid : 1'b1;
  assign pix  = (state_q == StRun) ? input_data : '0;
  assign emit = step && (fill_q == FillDone);

  // Row directly above the incoming pixel.
  line_buffer #(
    .Width (PX_SIZE),
    .Depth (IMAGE_WIDTH)
  ) u_line_buffer_0 (
    .clk_i  (clk),
    .rst_ni (resetn),
    .en_i   (step),
    .data_i (pix),
    .data_o (lb0_out)
  );

  // Row two above the incoming pixel.
  line_buffer #(
    .Width (PX_SIZE),
    .Depth (IMAGE_WIDTH)
  ) u_line_buffer_1 (
    .clk_i  (clk),
    .rst_ni (resetn),
    .en_i   (step),
    .data_i (lb0_out),
    .data_o (lb1_out)
  );

  // Shift the window left and load the new right column (top row oldest).
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb1_out;
    win_d[1][2] = lb0_out;
    win_d[2][2] = pix;
  end

  logic [GW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [GW-1:0] gx, gy, gx_abs, gy_abs;
  logic [MW-1:0] mag;
  logic [PX_SIZE-1:0] mag_sat;

  // Sobel on the post-shift window; Gx/Gy are two's complement in GW bits.
  always_comb begin
    gx_pos = GW'(win_d[0][2]) + GW'({win_d[1][2], 1'b0}) + GW'(win_d[2][2]);
    gx_neg = GW'(win_d[0][0]) + GW'({win_d[1][0], 1'b0}) + GW'(win_d[2][0]);
    gy_pos = GW'(win_d[2][0]) + GW'({win_d[2][1], 1'b0}) + GW'(win_d[2][2]);
    gy_neg = GW'(win_d[0][0]) + GW'({win_d[0][1], 1'b0}) + GW'(win_d[0][2]);
    gx     = gx_pos - gx_neg;
    gy     = gy_pos - gy_neg;
    gx_abs = gx[GW-1] ? (GW'(0) - gx) : gx;
    gy_abs = gy[GW-1] ? (GW'(0) - gy) : gy;
    mag    = MW'(gx_abs) + MW'(gy_abs);
    mag_sat = (mag > PxMax) ? {PX_SIZE{1'b1}} : mag[PX_SIZE-1:0];
  end

  assign border = (out_row_q == '0) || (out_row_q == RowLast) ||
                  (out_col_q == '0) || (out_col_q == ColLast);

  // Counters and RUN/FLUSH sequencing; nothing moves without a step.
  always_comb begin
    state_d     = state_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    flush_cnt_d = flush_cnt_q;
    fill_d      = fill_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    if (step) begin
      fill_d = (fill_q == FillDone) ? fill_q : fill_q + CW'(1);
      if (emit) begin
        if (out_col_q == ColLast) begin
          out_col_d = '0;
          out_row_d = (out_row_q == RowLast) ? '0 : out_row_q + RW'(1);
        end else begin
          out_col_d = out_col_q + CW'(1);
        end
      end
      if (state_q == StRun) begin
        if (in_col_q == ColLast) begin
          in_col_d = '0;
          in_row_d = (in_row_q == RowLast) ? '0 : in_row_q + RW'(1);
          if (in_row_q == RowLast) begin
            state_d     = StFlush;
            flush_cnt_d = '0;
          end
        end else begin
          in_col_d = in_col_q + CW'(1);
        end
      end else begin
        if (flush_cnt_q == FlushLast) begin
          // Last drain step: the next accepted pixel starts a fresh frame.
          state_d = StRun;
          fill_d  = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + CW'(1);
        end
      end
    end
  end

  // Output strobe; data holds its last value between strobes.
  always_comb begin
    out_valid_d = emit;
    out_data_d  = out_data_q;
    if (emit) begin
      out_data_d = border ? '0 : mag_sat;
    end
  end

  // Control and output state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StRun;
      in_col_q    <= '0;
      in_row_q    <= '0;
      flush_cnt_q <= '0;
      fill_q      <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      flush_cnt_q <= flush_cnt_d;
      fill_q      <= fill_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // 3x3 window registers, advanced on each step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (step) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  assign output_data       = out_data_q;
  assign output_data_valid = out_valid_q;

endmodule

// File: tb/tb_top.sv
// Randomized self-checking bench for the Sobel filter against a frame-level model.
module tb_top;

  localparam int W0 = 5;
  localparam int H0 = 5;
  localparam int W1 = 6;
  localparam int H1 = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] in_a = '0, in_b = '0;
  logic       vld_a = 1'b0, vld_b = 1'b0;
  logic [7:0] out_a, out_b;
  logic       ov_a, ov_b;

  always #5 clk = ~clk;

  top #(.PX_SIZE(8), .IMAGE_WIDTH(W0), .IMAGE_HEIGHT(H0)) u_dut_a (
    .clk               (clk),
    .resetn            (resetn),
    .input_data        (in_a),
    .input_data_valid  (vld_a),
    .output_data       (out_a),
    .output_data_valid (ov_a)
  );

  top #(.PX_SIZE(8), .IMAGE_WIDTH(W1), .IMAGE_HEIGHT(H1)) u_dut_b (
    .clk               (clk),
    .resetn            (resetn),
    .input_data        (in_b),
    .input_data_valid  (vld_b),
    .output_data       (out_b),
    .output_data_valid (ov_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int qa[$];
  int qb[$];
  int exp_q[$];
  int img[64];
  int nxt[64];
  int acc = 0;
  int first_acc = -1;
  int last_a = 0;
  int last_b = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Capture output strobes; between strobes the data must hold.
  always @(negedge clk) begin
    if (!resetn) begin
      check_val("rst_data_a", int'(out_a), 0);
      check_val("rst_valid_a", int'(ov_a), 0);
      last_a = 0;
      last_b = 0;
    end else begin
      if (ov_a) begin
        if (first_acc < 0) first_acc = acc;
        qa.push_back(int'(out_a));
        last_a = int'(out_a);
      end else begin
        check_val("hold_a", int'(out_a), last_a);
      end
      if (ov_b) begin
        qb.push_back(int'(out_b));
        last_b = int'(out_b);
      end else begin
        check_val("hold_b", int'(out_b), last_b);
      end
    end
  end

  always @(negedge resetn) begin
    last_a = 0;
    last_b = 0;
  end

  initial begin
    #300000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step(input int s, input int d, input bit v);
    if (s == 0) begin
      in_a = 8'(d);
      vld_a = v;
    end else begin
      in_b = 8'(d);
      vld_b = v;
    end
    @(posedge clk);
    #1;
    if (v && s == 0) acc++;
  endtask

  task automatic idle(input int s, input int n);
    repeat (n) step(s, 0, 1'b0);
  endtask

  task automatic drive_img(input int s, input int w, input int h, input int gap, input bit tail);
    for (int i = 0; i < w * h; i++) begin
      for (int g = 0; g < 4 && $urandom_range(0, 99) < gap; g++) begin
        step(s, $urandom_range(0, 255), 1'b0);
      end
      step(s, img[i], 1'b1);
    end
    if (tail) idle(s, w + 4);
  endtask

  function automatic int px(input int w, input int r, input int c);
    return img[r * w + c];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: whole-frame Sobel with zeroed border, appended in raster order.
  task automatic model_append(input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int e;
        int gx;
        int gy;
        e = 0;
        if (r > 0 && r < h - 1 && c > 0 && c < w - 1) begin
          gx = (px(w, r - 1, c + 1) + 2 * px(w, r, c + 1) + px(w, r + 1, c + 1))
             - (px(w, r - 1, c - 1) + 2 * px(w, r, c - 1) + px(w, r + 1, c - 1));
          gy = (px(w, r + 1, c - 1) + 2 * px(w, r + 1, c) + px(w, r + 1, c + 1))
             - (px(w, r - 1, c - 1) + 2 * px(w, r - 1, c) + px(w, r - 1, c + 1));
          e = iabs(gx) + iabs(gy);
          if (e > 255) e = 255;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic compare(input string tag, input int s);
    int got[$];
    int n;
    if (s == 0) got = qa;
    else got = qb;
    check_val($sformatf("%s_count", tag), got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_px%0d", tag, i), got[i], exp_q[i]);
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      img[i] = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
    end
  endtask

  task automatic fill_single();
    for (int i = 0; i < W0 * H0; i++) img[i] = 0;
    img[2 * W0 + 2] = 10;
  endtask

  task automatic start(input int s, input int w, input int h);
    exp_q.delete();
    model_append(w, h);
    if (s == 0) qa.delete();
    else qb.delete();
  endtask

  initial begin
    #1 resetn = 1'b0;
    #1;
    check_val("reset_data_a", int'(out_a), 0);
    check_val("reset_valid_a", int'(ov_a), 0);
    check_val("reset_data_b", int'(out_b), 0);
    check_val("reset_valid_b", int'(ov_b), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Flat image: every output zero; first output after W+2 accepted pixels.
    for (int i = 0; i < W0 * H0; i++) img[i] = 100;
    start(0, W0, H0);
    acc = 0;
    first_acc = -1;
    drive_img(0, W0, H0, 0, 1'b1);
    compare("const", 0);
    check_val("latency", first_acc, W0 + 2);

    // Vertical step edge on the 6x4 instance: saturates at the edge columns.
    for (int r = 0; r < H1; r++)
      for (int c = 0; c < W1; c++) img[r * W1 + c] = (c < 3) ? 0 : 200;
    start(1, W1, H1);
    drive_img(1, W1, H1, 0, 1'b1);
    compare("vstep", 1);

    // Single bright pixel, continuous then with random valid gaps.
    fill_single();
    start(0, W0, H0);
    drive_img(0, W0, H0, 0, 1'b1);
    compare("single", 0);
    start(0, W0, H0);
    drive_img(0, W0, H0, 30, 1'b1);
    compare("single_gaps", 0);

    // Random images on both geometries, with and without gaps.
    fill_rand(W0 * H0);
    start(0, W0, H0);
    drive_img(0, W0, H0, 0, 1'b1);
    compare("rand_a", 0);
    fill_rand(W1 * H1);
    start(1, W1, H1);
    drive_img(1, W1, H1, 25, 1'b1);
    compare("rand_b", 1);
    fill_rand(W0 * H0);
    start(0, W0, H0);
    drive_img(0, W0, H0, 40, 1'b1);
    compare("rand_a_gaps", 0);

    // Reset after 12 accepted pixels abandons the frame.
    fill_rand(W0 * H0);
    qa.delete();
    for (int i = 0; i < 12; i++) step(0, img[i], 1'b1);
    vld_a = 1'b0;
    #5;
    check_val("abort_count", qa.size(), 12 - (W0 + 1));
    resetn = 1'b0;
    #1;
    check_val("async_rst_data", int'(out_a), 0);
    check_val("async_rst_valid", int'(ov_a), 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    fill_rand(W0 * H0);
    start(0, W0, H0);
    drive_img(0, W0, H0, 0, 1'b1);
    compare("after_reset", 0);

    // Valid held through FLUSH: the first W+1 extras drop, the rest open the next frame.
    fill_single();
    start(0, W0, H0);
    for (int i = 0; i < W0 * H0; i++) nxt[i] = $urandom_range(0, 255);
    drive_img(0, W0, H0, 0, 1'b0);
    for (int j = 0; j < 10; j++) step(0, (j < W0 + 1) ? 77 : nxt[j - (W0 + 1)], 1'b1);
    for (int i = 0; i < W0 * H0; i++) img[i] = nxt[i];
    model_append(W0, H0);
    for (int i = 10 - (W0 + 1); i < W0 * H0; i++) step(0, img[i], 1'b1);
    idle(0, W0 + 4);
    compare("flush_extra", 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
